// File: rtl/bp_pkg.sv
// Types shared between the branch predictor and the branch resolve unit.
package bp_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        state_t      pred_state;
    } bp_meta_t;

endpackage

// File: rtl/bp_meta_fifo.sv
// In-order queue of prediction metadata; clear wins over push and pop.
module bp_meta_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  bp_meta_t push_data,
    input  logic     pop,
    input  logic     clear,
    output bp_meta_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    bp_meta_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pairs BTB predictions with ID-stage resolutions; drives predictor update and fetch redirect.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [31:0]      push_pc,
    input  logic             push_pred_taken,
    input  logic [31:0]      push_pred_target,
    input  logic [1:0]       push_pred_state,
    input  logic             res_valid,
    input  logic             res_is_branch,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    input  logic             flush_in,
    output logic             update_en,
    output logic             branch_taken,
    output logic [31:0]      resolved_pc,
    output logic [31:0]      resolved_target,
    output logic [1:0]       resolved_state,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             underflow_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    bp_meta_t    push_data;
    bp_meta_t    h;
    logic        full;
    logic        empty;
    logic        pop;
    logic        clear;
    logic [31:0] npc;
    logic [31:0] actual_next;
    logic [31:0] pred_next;
    logic        mispredict;

    assign push_ready = !full;

    always_comb begin
        push_data             = '0;
        push_data.pc          = push_pc;
        push_data.pred_taken  = push_pred_taken;
        push_data.pred_target = push_pred_target;
        push_data.pred_state  = state_t'(push_pred_state);
    end

    assign pop         = res_valid && !empty;
    assign npc         = h.pc + 32'd4;
    assign actual_next = (res_is_branch && res_taken) ? res_target : npc;
    assign pred_next   = h.pred_taken ? h.pred_target : npc;
    assign mispredict  = pop && (actual_next != pred_next);
    // A mispredict squashes the wrong path behind the head, including any same-cycle push.
    assign clear       = flush_in || mispredict;

    bp_meta_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_valid && push_ready),
        .push_data (push_data),
        .pop       (pop),
        .clear     (clear),
        .head      (h),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_en       <= 1'b0;
            branch_taken    <= 1'b0;
            resolved_pc     <= '0;
            resolved_target <= '0;
            resolved_state  <= '0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
            underflow_err   <= 1'b0;
            branch_cnt      <= '0;
            mispred_cnt     <= '0;
        end else begin
            update_en      <= 1'b0;
            redirect_valid <= 1'b0;
            if (res_valid && empty) begin
                underflow_err <= 1'b1;
            end
            if (pop && res_is_branch) begin
                update_en       <= 1'b1;
                branch_taken    <= res_taken;
                resolved_pc     <= h.pc;
                resolved_target <= actual_next;
                resolved_state  <= h.pred_state;
                if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
            end
            if (mispredict) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= actual_next;
                if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit (narrow counters to reach saturation quickly).
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic [31:0] push_pred_target;
    logic [1:0]  push_pred_state;
    logic        res_valid;
    logic        res_is_branch;
    logic        res_taken;
    logic [31:0] res_target;
    logic        flush_in;
    logic        update_en;
    logic        branch_taken;
    logic [31:0] resolved_pc;
    logic [31:0] resolved_target;
    logic [1:0]  resolved_state;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        underflow_err;
    logic [3:0]  branch_cnt;
    logic [3:0]  mispred_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    branch_resolve_unit #(.DEPTH(4), .CNT_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .push_valid       (push_valid),
        .push_ready       (push_ready),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .push_pred_state  (push_pred_state),
        .res_valid        (res_valid),
        .res_is_branch    (res_is_branch),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .flush_in         (flush_in),
        .update_en        (update_en),
        .branch_taken     (branch_taken),
        .resolved_pc      (resolved_pc),
        .resolved_target  (resolved_target),
        .resolved_state   (resolved_state),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .underflow_err    (underflow_err),
        .branch_cnt       (branch_cnt),
        .mispred_cnt      (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid = 1'b0; res_valid = 1'b0; flush_in = 1'b0;
        res_is_branch = 1'b0; res_taken = 1'b0; res_target = '0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic [1:0] st);
        push_valid = 1'b1; push_pc = pc; push_pred_taken = tk;
        push_pred_target = tgt; push_pred_state = st;
    endtask

    task automatic set_res(input logic br, input logic tk, input logic [31:0] tgt);
        res_valid = 1'b1; res_is_branch = br; res_taken = tk; res_target = tgt;
    endtask

    initial begin
        rst_n = 1'b0;
        push_pc = '0; push_pred_taken = 1'b0; push_pred_target = '0; push_pred_state = '0;
        idle();
        #22;
        check("rst_push_ready", push_ready, 1);
        check("rst_update_en", update_en, 0);
        check("rst_redirect", redirect_valid, 0);
        check("rst_branch_cnt", branch_cnt, 0);
        check("rst_mispred_cnt", mispred_cnt, 0);
        check("rst_underflow", underflow_err, 0);
        rst_n = 1'b1;
        tick();

        // 1: correct taken prediction
        set_push(32'h100, 1, 32'h140, 2'b10); tick(); idle();
        set_res(1, 1, 32'h140); tick(); idle();
        check("t1_update_en", update_en, 1);
        check("t1_resolved_pc", resolved_pc, 32'h100);
        check("t1_resolved_target", resolved_target, 32'h140);
        check("t1_resolved_state", resolved_state, 2'b10);
        check("t1_branch_taken", branch_taken, 1);
        check("t1_redirect", redirect_valid, 0);
        check("t1_branch_cnt", branch_cnt, 1);
        check("t1_mispred_cnt", mispred_cnt, 0);
        tick();
        check("t1_update_pulse", update_en, 0);

        // 2: taken mispredict flushes wrong path; same-cycle push dropped
        set_push(32'h200, 0, 32'h0, 2'b01); tick();
        set_push(32'h204, 0, 32'h0, 2'b00); tick();
        set_push(32'h208, 0, 32'h0, 2'b00); tick(); idle();
        set_push(32'h20C, 0, 32'h0, 2'b00);
        set_res(1, 1, 32'h300); tick(); idle();
        check("t2_redirect", redirect_valid, 1);
        check("t2_redirect_pc", redirect_pc, 32'h300);
        check("t2_update_en", update_en, 1);
        check("t2_resolved_state", resolved_state, 2'b01);
        check("t2_resolved_target", resolved_target, 32'h300);
        check("t2_mispred_cnt", mispred_cnt, 1);
        check("t2_branch_cnt", branch_cnt, 2);
        check("t2_push_ready", push_ready, 1);
        tick();
        check("t2_redirect_pulse", redirect_valid, 0);
        set_res(1, 0, 32'h0); tick(); idle();
        check("t2_empty_no_update", update_en, 0);
        check("t2_empty_no_redirect", redirect_valid, 0);
        check("t2_underflow", underflow_err, 1);

        // 3: non-branch predicted taken (alias)
        set_push(32'h400, 1, 32'h500, 2'b11); tick(); idle();
        set_res(0, 0, 32'h0); tick(); idle();
        check("t3_redirect", redirect_valid, 1);
        check("t3_redirect_pc", redirect_pc, 32'h404);
        check("t3_update_en", update_en, 0);
        check("t3_branch_cnt", branch_cnt, 2);
        check("t3_mispred_cnt", mispred_cnt, 2);
        check("t3_resolved_pc_hold", resolved_pc, 32'h200);

        // 4: full queue, rejected push, FIFO order
        for (int i = 0; i < 4; i++) begin
            set_push(32'h600 + 32'(4 * i), 0, 32'h0, 2'b00); tick();
        end
        check("t4_full_ready", push_ready, 0);
        set_push(32'h610, 0, 32'h0, 2'b00); tick();
        check("t4_still_full", push_ready, 0);
        set_res(1, 0, 32'h0); tick();
        push_valid = 1'b0;
        check("t4_pop0_pc", resolved_pc, 32'h600);
        check("t4_pop0_redirect", redirect_valid, 0);
        check("t4_ready_after_pop", push_ready, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("t4_order_pc", resolved_pc, 32'h600 + 32'(4 * i));
            check("t4_order_update", update_en, 1);
        end
        tick(); idle();
        check("t4_fifth_dropped", update_en, 0);
        check("t4_branch_cnt", branch_cnt, 6);

        // flush_in: head still resolved, rest discarded
        set_push(32'h700, 0, 32'h0, 2'b01); tick();
        set_push(32'h704, 0, 32'h0, 2'b01); tick(); idle();
        set_res(1, 0, 32'h0); flush_in = 1'b1; tick(); idle();
        check("fl_update_en", update_en, 1);
        check("fl_resolved_pc", resolved_pc, 32'h700);
        check("fl_resolved_target", resolved_target, 32'h704);
        set_res(1, 0, 32'h0); tick(); idle();
        check("fl_queue_empty", update_en, 0);
        check("fl_branch_cnt", branch_cnt, 7);

        // 5: async reset mid-stream
        set_push(32'h900, 0, 32'h0, 2'b00); tick(); idle();
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_underflow", underflow_err, 0);
        check("t5_rst_branch_cnt", branch_cnt, 0);
        check("t5_rst_mispred_cnt", mispred_cnt, 0);
        check("t5_rst_ready", push_ready, 1);
        #4 rst_n = 1'b1;
        tick();
        set_res(1, 1, 32'h0); tick(); idle();
        check("t5_uf_update", update_en, 0);
        check("t5_uf_redirect", redirect_valid, 0);
        check("t5_uf_flag", underflow_err, 1);

        // 6: counter saturation
        for (int i = 0; i < 20; i++) begin
            set_push(32'h800, 0, 32'h0, 2'b00); tick(); idle();
            set_res(1, 1, 32'h900); tick(); idle();
        end
        check("t6_mispred_sat", mispred_cnt, 4'hF);
        check("t6_branch_sat", branch_cnt, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
